// File: rtl/game_round_ctrl.sv
// game_round_ctrl: BCD quiz round sequencer with timed answer window, scoring and result hold.
module game_round_ctrl #(
  parameter int         TICK_DIV  = 100_000,
  parameter int         ANSWER_MS = 5000,
  parameter int         RESULT_MS = 1000,
  parameter int         ROUNDS    = 10,
  parameter logic [4:0] LFSR_SEED = 5'h1B
) (
  input  logic       CLK,
  input  logic       R,
  input  logic       BTN,
  input  logic [4:0] SW,
  output logic [3:0] Q1,
  output logic       HEX,
  output logic       DEC,
  output logic [3:0] ROUND,
  output logic [3:0] SCORE,
  output logic       CORRECT,
  output logic       BUSY,
  output logic       DONE
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  typedef enum logic [2:0] {IDLE, SHOW, ANSWER, RESULT, FINISH} state_t;
  state_t state_q, state_d;
  logic [2:0] sync_q;
  logic [4:0] lfsr_q;
  logic [PW-1:0] presc_q;
  logic [15:0] tick_q;
  logic [3:0] q1_q, q1_d, round_q, round_d, score_q, score_d;
  logic hex_q, hex_d, dec_q, dec_d, correct_q, correct_d, busy_q, done_q;
  logic btn_rise, tick_end, ans_to, res_to, right;
  logic [3:0] q_raw, q_val;
  assign btn_rise = sync_q[1] & ~sync_q[2];
  assign tick_end = presc_q == PW'(TICK_DIV - 1);
  assign ans_to   = tick_end && tick_q == 16'(ANSWER_MS - 1);
  assign res_to   = tick_end && tick_q == 16'(RESULT_MS - 1);
  assign right    = SW[3:0] == q1_q && SW[4] == hex_q;
  // Decimal questions fold 10..15 back into 0..5 so the digit stays a valid BCD value.
  assign q_raw = lfsr_q[3:0];
  assign q_val = (!lfsr_q[4] && q_raw > 4'd9) ? q_raw - 4'd10 : q_raw;
  always_comb begin
    state_d   = state_q;
    q1_d      = q1_q;
    hex_d     = hex_q;
    dec_d     = dec_q;
    round_d   = round_q;
    score_d   = score_q;
    correct_d = correct_q;
    case (state_q)
      IDLE: if (btn_rise) begin
        state_d = SHOW;
        score_d = '0;
        round_d = 4'd1;
      end
      SHOW: state_d = ANSWER;
      ANSWER: if (btn_rise || ans_to) begin
        state_d   = RESULT;
        correct_d = btn_rise && right;
        score_d   = (btn_rise && right && score_q < 4'(ROUNDS)) ? score_q + 4'd1 : score_q;
      end
      RESULT: if (res_to) begin
        correct_d = 1'b0;
        state_d   = round_q == 4'(ROUNDS) ? FINISH : SHOW;
        round_d   = round_q == 4'(ROUNDS) ? round_q : round_q + 4'd1;
      end
      FINISH: if (btn_rise) begin
        state_d = IDLE;
        round_d = '0;
        score_d = '0;
      end
      default: state_d = IDLE;
    endcase
    // A new question is drawn from the LFSR on the edge that enters SHOW.
    if (state_d == SHOW && state_q != SHOW) begin
      q1_d  = q_val;
      hex_d = lfsr_q[4];
      dec_d = ~lfsr_q[4];
    end
    if (state_d == FINISH || state_d == IDLE) begin
      q1_d  = '0;
      hex_d = 1'b0;
      dec_d = 1'b0;
    end
  end
  always_ff @(posedge CLK) begin
    if (!R) begin
      state_q   <= IDLE;
      sync_q    <= '0;
      lfsr_q    <= LFSR_SEED;
      presc_q   <= '0;
      tick_q    <= '0;
      q1_q      <= '0;
      hex_q     <= 1'b0;
      dec_q     <= 1'b0;
      round_q   <= '0;
      score_q   <= '0;
      correct_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[1:0], BTN};
      lfsr_q    <= {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
      presc_q   <= (state_d != state_q || tick_end) ? '0 : presc_q + PW'(1);
      tick_q    <= state_d != state_q ? '0 : tick_q + 16'(tick_end);
      q1_q      <= q1_d;
      hex_q     <= hex_d;
      dec_q     <= dec_d;
      round_q   <= round_d;
      score_q   <= score_d;
      correct_q <= correct_d;
      busy_q    <= state_d == SHOW || state_d == ANSWER || state_d == RESULT;
      done_q    <= state_d == FINISH;
    end
  end
  assign Q1      = q1_q;
  assign HEX     = hex_q;
  assign DEC     = dec_q;
  assign ROUND   = round_q;
  assign SCORE   = score_q;
  assign CORRECT = correct_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
endmodule

// File: tb/tb_game_round_ctrl.sv
// tb_game_round_ctrl: directed checks of round sequencing, scoring, timeout and reset behaviour.
module tb_game_round_ctrl;
  localparam int TD = 4, AMS = 10, RMS = 3, RN = 3;
  logic CLK = 0, R = 0, BTN = 0;
  logic [4:0] SW = '0;
  logic [3:0] Q1, ROUND, SCORE;
  logic HEX, DEC, CORRECT, BUSY, DONE;
  int n_assert = 0, n_fail = 0;
  int exp_round, exp_score;
  logic [4:0] m_q, snap_q;

  game_round_ctrl #(.TICK_DIV(TD), .ANSWER_MS(AMS), .RESULT_MS(RMS), .ROUNDS(RN), .LFSR_SEED(5'h1B)) dut (
    .CLK(CLK), .R(R), .BTN(BTN), .SW(SW), .Q1(Q1), .HEX(HEX), .DEC(DEC),
    .ROUND(ROUND), .SCORE(SCORE), .CORRECT(CORRECT), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // Reference x^5+x^3+1 LFSR; snap_q holds the value seen just before the latest edge.
  always @(posedge CLK) begin
    m_q    <= !R ? 5'h1B : {m_q[3:0], m_q[4] ^ m_q[2]};
    snap_q <= m_q;
  end

  function automatic logic [4:0] qexp(input logic [4:0] l);
    return {l[4], (!l[4] && l[3:0] > 4'd9) ? l[3:0] - 4'd10 : l[3:0]};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Press lands as btn_rise on the third edge; returns at the negedge after it.
  task automatic press();
    BTN = 1;
    tick(3);
    BTN = 0;
  endtask

  // Called at the negedge just after SHOW entry.
  task automatic do_round(input int kind);
    logic [4:0] e;
    logic exp_c;
    int off;
    e = qexp(snap_q);
    chk("q1", 8'(Q1), 8'(e[3:0]));
    chk("hex", 8'(HEX), 8'(e[4]));
    chk("dec", 8'(DEC), 8'(!e[4]));
    chk("dec_le9", 8'(DEC && Q1 > 4'd9), 8'd0);
    chk("busy_show", 8'(BUSY), 8'd1);
    chk("round", 8'(ROUND), 8'(exp_round));
    tick(1);
    off = 0;
    exp_c = 0;
    case (kind)
      0: begin SW = e; tick(2); press(); exp_c = 1; end
      1: begin SW = {~e[4], e[3:0]}; tick(2); press(); end
      2: begin SW = e; tick(40); end
      3: begin SW = e; tick(37); press(); exp_c = 1; end
      4: begin SW = e; tick(38); press(); off = 1; end
      default: begin SW = {e[4], e[3:0] ^ 4'd1}; tick(2); press(); end
    endcase
    if (exp_c) exp_score++;
    chk($sformatf("correct_k%0d", kind), 8'(CORRECT), 8'(exp_c));
    chk("score", 8'(SCORE), 8'(exp_score));
    tick(11 - off);
    chk("correct_hold", 8'(CORRECT), 8'(exp_c));
    chk("round_hold", 8'(ROUND), 8'(exp_round));
    tick(1);
    chk("correct_clr", 8'(CORRECT), 8'd0);
    if (exp_round < RN) begin
      exp_round++;
      chk("round_next", 8'(ROUND), 8'(exp_round));
    end else begin
      chk("done", 8'(DONE), 8'd1);
      chk("round_fin", 8'(ROUND), 8'(RN));
      chk("q1_fin", 8'({Q1, HEX, DEC}), 8'd0);
      chk("busy_fin", 8'(BUSY), 8'd0);
      chk("score_fin", 8'(SCORE), 8'(exp_score));
    end
  endtask

  task automatic play_game(input int k0, input int k1, input int k2);
    tick($urandom_range(3, 9));
    press();
    exp_round = 1;
    exp_score = 0;
    chk("score_start", 8'(SCORE), 8'd0);
    do_round(k0);
    do_round(k1);
    do_round(k2);
    tick(2);
    press();
    chk("idle_done", 8'(DONE), 8'd0);
    chk("idle_score", 8'(SCORE), 8'd0);
    chk("idle_round", 8'(ROUND), 8'd0);
    chk("idle_busy", 8'(BUSY), 8'd0);
  endtask

  initial begin
    R = 0;
    tick(3);
    R = 1;
    tick(20);
    chk("rst_outs", 8'({Q1, HEX, DEC, CORRECT, BUSY}), 8'd0);
    chk("rst_round", 8'(ROUND), 8'd0);
    chk("rst_score", 8'(SCORE), 8'd0);
    chk("rst_done", 8'(DONE), 8'd0);
    play_game(0, 2, 1);
    play_game(3, 4, 5);
    play_game(0, 0, 0);
    for (int g = 0; g < 67; g++) begin
      int k[3];
      for (int i = 0; i < 3; i++) begin
        k[i] = $urandom_range(0, 2);
        if (k[i] == 2) k[i] = 5;
      end
      play_game(k[0], k[1], k[2]);
    end
    tick(4);
    press();
    exp_round = 1;
    exp_score = 0;
    do_round(0);
    tick(2);
    R = 0;
    tick(1);
    chk("midrst_busy", 8'(BUSY), 8'd0);
    chk("midrst_round", 8'(ROUND), 8'd0);
    chk("midrst_score", 8'(SCORE), 8'd0);
    chk("midrst_q", 8'({Q1, HEX, DEC}), 8'd0);
    R = 1;
    play_game(0, 1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
